// File: rtl/lcd_spi_writer_if.sv
// lcd_spi_writer_if: request handshake and 4-wire LCD SPI bus.
// master = word source side, slave = the serialiser.
interface lcd_spi_writer_if;
    logic [8:0] data;
    logic       en_write;
    logic       wr_done;
    logic       busy;
    logic       cs;
    logic       dc;
    logic       sclk;
    logic       mosi;

    modport master (
        output data, en_write,
        input  wr_done, busy, cs, dc, sclk, mosi
    );

    modport slave (
        input  data, en_write,
        output wr_done, busy, cs, dc, sclk, mosi
    );
endinterface

// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: 9-bit LCD word to 4-wire SPI (mode 0), MSB first.
// Define LCD_WR_FIFO_EN for a 4-deep input FIFO in front of the FSM.
module lcd_spi_writer #(
    parameter int CLK_DIV = 2
) (
    input  logic            sys_clk_50MHz,
    input  logic            sys_rst_n,
    lcd_spi_writer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE
    } state_t;

    state_t     state;
    logic [7:0] div;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       cs_q;
    logic       dc_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       done_q;
    logic       last;
    logic       go;
    logic [8:0] word;

    assign last = (div == 8'(CLK_DIV - 1));

`ifdef LCD_WR_FIFO_EN
    logic [8:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       push;

    assign push     = bus.en_write && (count != 3'd4);
    assign go       = (state == IDLE) && (count != 3'd0);
    assign word     = mem[rd_ptr];
    assign bus.busy = (count == 3'd4);

    // Push and pop in one cycle are both honoured; count nets them.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (go) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, go};
        end
    end
`else
    assign go       = (state == IDLE) && bus.en_write;
    assign word     = bus.data;
    assign bus.busy = (state != IDLE);
`endif

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div    <= last ? 8'd0 : div + 8'd1;
            unique case (state)
                IDLE: begin
                    div <= 8'd0;
                    if (go) begin
                        state   <= SETUP;
                        shreg   <= word[6:0];
                        dc_q    <= word[8];
                        mosi_q  <= word[7];
                        cs_q    <= 1'b0;
                        bit_cnt <= 3'd7;
                    end
                end
                SETUP: begin
                    if (last) begin
                        state  <= SHIFT_HI;
                        sclk_q <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (last) begin
                        sclk_q <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            state <= HOLD;
                        end else begin
                            // mosi moves on the falling edge only
                            state   <= SHIFT_LO;
                            mosi_q  <= shreg[6];
                            shreg   <= {shreg[5:0], 1'b0};
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                end
                SHIFT_LO: begin
                    if (last) begin
                        state  <= SHIFT_HI;
                        sclk_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (last) begin
                        state  <= DONE;
                        cs_q   <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    div   <= 8'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cs      = cs_q;
    assign bus.dc      = dc_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.wr_done = done_q;
endmodule

// File: tb/tb_lcd_spi_writer.sv
// tb_lcd_spi_writer: two DUTs (CLK_DIV 2 and 1), frame monitor,
// word-level reference model, directed table and random traffic.
`timescale 1ns/1ps
module tb_lcd_spi_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lcd_spi_writer_if bus0 ();
    lcd_spi_writer_if bus1 ();

    lcd_spi_writer #(.CLK_DIV(2)) dut0 (
        .sys_clk_50MHz(clk),
        .sys_rst_n    (rst_n),
        .bus          (bus0)
    );

    lcd_spi_writer #(.CLK_DIV(1)) dut1 (
        .sys_clk_50MHz(clk),
        .sys_rst_n    (rst_n),
        .bus          (bus1)
    );

    logic [1:0] o_cs, o_dc, o_sclk, o_mosi, o_done, o_busy;
    assign o_cs   = {bus1.cs, bus0.cs};
    assign o_dc   = {bus1.dc, bus0.dc};
    assign o_sclk = {bus1.sclk, bus0.sclk};
    assign o_mosi = {bus1.mosi, bus0.mosi};
    assign o_done = {bus1.wr_done, bus0.wr_done};
    assign o_busy = {bus1.busy, bus0.busy};

    typedef struct {
        logic [8:0] w;
        int         c;
    } exp_t;

    typedef struct {
        int         k;
        logic [8:0] word;
        logic [7:0] bits;
        logic       dc;
        int         len;
        int         lat;
    } vec_t;

`ifdef LCD_WR_FIFO_EN
    localparam int FIFO_LAG = 1;
`else
    localparam int FIFO_LAG = 0;
`endif

    exp_t       eq [2][$];
    logic [8:0] fq [2][$];
    int         nf [2];
    int         cdv [2];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    bit         inf [2];
    int         len [2];
    int         rises [2];
    int         last_rise [2];
    logic [7:0] bits [2];
    logic       dc0 [2];
    bit         psclk [2];
    bit         pmosi [2];
    int         tot_done [2];
    int         tot_rise [2];
    logic [7:0] l_bits [2];
    logic       l_dc [2];
    int         l_len [2];
    int         l_rises [2];
    int         l_cyc [2];

    task automatic chk(input string n, input int k,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d want %0d (cyc %0d)",
                     n, k, act, exp, cyc);
        end
    endtask

    // Frame-level observation of one bus for the current cycle.
    task automatic mon(input int k);
        logic s, m;
        exp_t e;
        s = o_sclk[k];
        m = o_mosi[k];
        if (o_cs[k]) begin
            inf[k] = 1'b0;
            chk("sclk_idle", k, int'(s), 0);
        end else begin
            if (!inf[k]) begin
                inf[k]   = 1'b1;
                len[k]   = 0;
                rises[k] = 0;
                bits[k]  = '0;
                dc0[k]   = o_dc[k];
            end
            len[k]++;
            chk("dc_stable", k, int'(o_dc[k]), int'(dc0[k]));
            if (s && psclk[k])
                chk("mosi_stable", k, int'(m), int'(pmosi[k]));
        end
        if (s && !psclk[k]) begin
            tot_rise[k]++;
            if (!o_cs[k]) begin
                if (rises[k] > 0)
                    chk("sclk_period", k, cyc - last_rise[k], 2 * cdv[k]);
                rises[k]++;
                bits[k]      = {bits[k][6:0], m};
                last_rise[k] = cyc;
            end
        end
        if (o_done[k]) begin
            tot_done[k]++;
            l_bits[k]  = bits[k];
            l_dc[k]    = dc0[k];
            l_len[k]   = len[k];
            l_rises[k] = rises[k];
            l_cyc[k]   = cyc;
            chk("done_expected", k, int'(eq[k].size() > 0), 1);
            if (eq[k].size() > 0) begin
                e = eq[k].pop_front();
                chk("m_bits", k, int'(bits[k]), int'(e.w[7:0]));
                chk("m_dc", k, int'(dc0[k]), int'(e.w[8]));
                chk("m_cs_len", k, len[k], 17 * cdv[k]);
                chk("m_rises", k, rises[k], 8);
                chk("m_latency", k, cyc - e.c, 17 * cdv[k] + 1);
            end
        end
        psclk[k] = s;
        pmosi[k] = m;
    endtask

    // Word-level model: frame takes 17*CLK_DIV+1 cycles after accept.
    task automatic model(input int k, input logic en, input logic [8:0] d);
        exp_t e;
`ifdef LCD_WR_FIFO_EN
        bit full;
        full = (fq[k].size() == 4);
        if (cyc >= nf[k] && fq[k].size() > 0) begin
            e.w = fq[k].pop_front();
            e.c = cyc;
            eq[k].push_back(e);
            nf[k] = cyc + 17 * cdv[k] + 2;
        end
        if (en && !full) fq[k].push_back(d);
`else
        if (en && cyc >= nf[k]) begin
            e.w = d;
            e.c = cyc;
            eq[k].push_back(e);
            nf[k] = cyc + 17 * cdv[k] + 2;
        end
`endif
    endtask

    task automatic tick(input logic e0, input logic [8:0] d0,
                        input logic e1, input logic [8:0] d1);
        logic       en [2];
        logic [8:0] d [2];
        en[0] = e0; d[0] = d0;
        en[1] = e1; d[1] = d1;
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                mon(k);
`ifdef LCD_WR_FIFO_EN
                chk("busy", k, int'(o_busy[k]), int'(fq[k].size() == 4));
`else
                chk("busy", k, int'(o_busy[k]), int'(cyc < nf[k]));
`endif
                model(k, en[k], d[k]);
            end
        end
        bus0.en_write = e0;
        bus0.data     = d0;
        bus1.en_write = e1;
        bus1.data     = d1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 9'h0, 1'b0, 9'h0);
    endtask

    task automatic wait_done(input int k, input int target, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (tot_done[k] >= target) break;
            idle(1);
        end
        chk("done_timeout", k, int'(tot_done[k] >= target), 1);
    endtask

    task automatic rst_chk(input int k);
        chk("rst_cs", k, int'(o_cs[k]), 1);
        chk("rst_sclk", k, int'(o_sclk[k]), 0);
        chk("rst_mosi", k, int'(o_mosi[k]), 0);
        chk("rst_busy", k, int'(o_busy[k]), 0);
        chk("rst_done", k, int'(o_done[k]), 0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            eq[k].delete();
            fq[k].delete();
            nf[k]    = 0;
            inf[k]   = 1'b0;
            psclk[k] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        vec_t v;
        int   n0, n1, rc;
        int   r0 [2];
        logic e0, e1;
        logic [8:0] d0, d1;

        cdv[0] = 2;
        cdv[1] = 1;
        vt[0] = '{0, 9'h036, 8'b0011_0110, 1'b0, 34, 35};
        vt[1] = '{0, 9'h1A5, 8'b1010_0101, 1'b1, 34, 35};
        vt[2] = '{1, 9'h100, 8'b0000_0000, 1'b1, 17, 18};
        vt[3] = '{1, 9'h0C3, 8'b1100_0011, 1'b0, 17, 18};
        vt[4] = '{0, 9'h181, 8'b1000_0001, 1'b1, 34, 35};

        bus0.en_write = 1'b0;
        bus0.data     = '0;
        bus1.en_write = 1'b0;
        bus1.data     = '0;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            rst_chk(k);
            chk("rst_dc", k, int'(o_dc[k]), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            v  = vt[i];
            n0 = tot_done[v.k];
            rc = cyc;
            if (v.k == 0) tick(1'b1, v.word, 1'b0, 9'h0);
            else          tick(1'b0, 9'h0, 1'b1, v.word);
            wait_done(v.k, n0 + 1, 200);
            chk("vec_bits", v.k, int'(l_bits[v.k]), int'(v.bits));
            chk("vec_dc", v.k, int'(l_dc[v.k]), int'(v.dc));
            chk("vec_cs_len", v.k, l_len[v.k], v.len);
            chk("vec_rises", v.k, l_rises[v.k], 8);
            chk("vec_latency", v.k, l_cyc[v.k] - rc, v.lat + FIFO_LAG);
            idle(3);
        end

`ifndef LCD_WR_FIFO_EN
        n0 = tot_done[0];
        tick(1'b1, 9'h036, 1'b0, 9'h0);
        idle(9);
        chk("busy_mid", 0, int'(o_busy[0]), 1);
        tick(1'b1, 9'h0FF, 1'b0, 9'h0);
        wait_done(0, n0 + 1, 100);
        idle(40);
        chk("drop_busy_done", 0, tot_done[0] - n0, 1);
        chk("drop_busy_word", 0, int'(l_bits[0]), 8'h36);

        n1 = tot_done[1];
        tick(1'b0, 9'h0, 1'b1, 9'h055);
        idle(17);
        chk("done_cycle", 1, int'(o_done[1]), 1);
        tick(1'b0, 9'h0, 1'b1, 9'h0AA);
        tick(1'b0, 9'h0, 1'b1, 9'h133);
        wait_done(1, n1 + 2, 100);
        idle(30);
        chk("drop_done_cnt", 1, tot_done[1] - n1, 2);
        chk("drop_done_word", 1, int'(l_bits[1]), 8'h33);
        chk("drop_done_dc", 1, int'(l_dc[1]), 1);
`else
        n0 = tot_done[0];
        for (int i = 1; i <= 6; i++) tick(1'b1, 9'(i), 1'b0, 9'h0);
        chk("fifo_full_busy", 0, int'(o_busy[0]), 1);
        wait_done(0, n0 + 5, 400);
        idle(60);
        chk("fifo_done_cnt", 0, tot_done[0] - n0, 5);
        chk("fifo_last_word", 0, int'(l_bits[0]), 5);
`endif

        tick(1'b1, 9'h0F0, 1'b0, 9'h0);
        for (int i = 0; i < 100; i++) begin
            if (inf[0] && rises[0] >= 4) break;
            idle(1);
        end
        chk("reach_bit4", 0, rises[0], 4);
        #2;
        chk("pre_rst_sclk", 0, int'(o_sclk[0]), 1);
        chk("pre_rst_mosi", 0, int'(o_mosi[0]), 1);
        rst_n = 1'b0;
        #1;
        rst_chk(0);
        rst_chk(1);
        clear_model();
        @(negedge clk);
        cyc++;
        idle(2);
        rst_n = 1'b1;
        r0[0] = tot_done[0];
        r0[1] = tot_done[1];
        n0 = tot_rise[0];
        n1 = tot_rise[1];
        idle(60);
        chk("post_rst_done", 0, tot_done[0] - r0[0], 0);
        chk("post_rst_done", 1, tot_done[1] - r0[1], 0);
        chk("post_rst_rise", 0, tot_rise[0] - n0, 0);
        chk("post_rst_rise", 1, tot_rise[1] - n1, 0);

        repeat (1500) begin
            e0 = ($urandom_range(0, 9) == 0);
            e1 = ($urandom_range(0, 5) == 0);
            d0 = 9'($urandom);
            d1 = 9'($urandom);
            tick(e0, d0, e1, d1);
        end
        idle(250);
        for (int k = 0; k < 2; k++) begin
            chk("drained", k, eq[k].size() + fq[k].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
